sigmoid_stream_ctrl: RTL and testbench

SIGMOID_STREAM_CTRL -- requirements
Module: sigmoid_stream_ctrl

---
 rtl/sigmoid_stream_ctrl.sv | 117 +++++++++++
 tb/tb_sigmoid_stream_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigmoid_stream_ctrl.sv
// sigmoid_stream_ctrl: AXI-stream wrapper around a free-running fixed-latency
// sigmoid pipeline. It tracks in-flight operands with a valid shift register,
// captures pipeline results into a first-word-fall-through FIFO, and throttles
// upstream so in-flight plus buffered results never exceed the FIFO depth.
// Optional macro SIG_TLAST_EN adds s_axis_tlast/m_axis_tlast carried alongside
// each beat through a parallel shift register and FIFO bit.
module sigmoid_stream_ctrl #(
   parameter int unsigned LATENCY = 8,
   parameter int unsigned DEPTH   = 16
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic [31:0] s_axis_tdata,
`ifdef SIG_TLAST_EN
   input  logic        s_axis_tlast,
   output logic        m_axis_tlast,
`endif
   output logic [31:0] sig_in,
   input  logic [31:0] sig_out,
   output logic        m_axis_tvalid,
   input  logic        m_axis_tready,
   output logic [31:0] m_axis_tdata
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH) + 2;

   logic               r_tready;
   logic               r_tvalid;
   logic [LATENCY-1:0] r_sr;
   logic [CW-1:0]      r_inflight;
   logic [CW-1:0]      r_count;
   logic [AW-1:0]      r_wptr;
   logic [AW-1:0]      r_rptr;
   logic [31:0]        r_mem [DEPTH];

   logic               w_beat;
   logic               w_cap;
   logic               w_pop;
   logic [CW-1:0]      w_inflight_n;
   logic [CW-1:0]      w_count_n;

   // Handshake decode and next occupancy of the pipeline and the FIFO
   always_comb begin
      w_beat       = s_axis_tvalid & r_tready;
      w_cap        = r_sr[LATENCY-1];
      w_pop        = r_tvalid & m_axis_tready;
      w_inflight_n = r_inflight;
      w_count_n    = r_count;
      case ({w_beat, w_cap})
         2'b10:   w_inflight_n = r_inflight + CW'(1);
         2'b01:   w_inflight_n = r_inflight - CW'(1);
         default: w_inflight_n = r_inflight;
      endcase
      case ({w_cap, w_pop})
         2'b10:   w_count_n = r_count + CW'(1);
         2'b01:   w_count_n = r_count - CW'(1);
         default: w_count_n = r_count;
      endcase
   end

   // Control state: valid shift register, counters, pointers, registered flags
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_sr       <= '0;
         r_inflight <= '0;
         r_count    <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_tready   <= 1'b0;
         r_tvalid   <= 1'b0;
      end else begin
         r_sr       <= (r_sr << 1) | LATENCY'(w_beat);
         r_inflight <= w_inflight_n;
         r_count    <= w_count_n;
         if (w_cap) r_wptr <= r_wptr + AW'(1);
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         // Reserve a FIFO slot for every operand still inside the pipeline
         r_tready   <= (w_inflight_n + w_count_n) < CW'(DEPTH);
         r_tvalid   <= (w_count_n != '0);
      end
   end

   // Result storage; contents need no reset since occupancy gates visibility
   always_ff @(posedge aclk) begin
      if (aresetn && w_cap) r_mem[r_wptr] <= sig_out;
   end

`ifdef SIG_TLAST_EN
   logic [LATENCY-1:0] r_sr_last;
   logic               r_mem_last [DEPTH];

   // tlast rides a shift register parallel to the valid bits
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_sr_last <= '0;
      end else begin
         r_sr_last <= (r_sr_last << 1) | LATENCY'(w_beat & s_axis_tlast);
      end
   end

   // tlast FIFO bit written alongside its result
   always_ff @(posedge aclk) begin
      if (aresetn && w_cap) r_mem_last[r_wptr] <= r_sr_last[LATENCY-1];
   end

   assign m_axis_tlast = r_mem_last[r_rptr];
`endif

   assign s_axis_tready = r_tready;
   assign sig_in        = w_beat ? s_axis_tdata : 32'h0000_0000;
   assign m_axis_tvalid = r_tvalid;
   assign m_axis_tdata  = r_mem[r_rptr];

endmodule

// File: tb/tb_sigmoid_stream_ctrl.sv
// Bench for sigmoid_stream_ctrl with the sigmoid replaced by a LATENCY-deep
// delay line. A queue holds accepted beats in order; every result leaving the
// block must match the head of that queue. Define SIG_TLAST_EN to cover tlast.
module tb_sigmoid_stream_ctrl;

   localparam int unsigned LATENCY = 8;
   localparam int unsigned DEPTH   = 16;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [31:0] s_axis_tdata;
   logic        s_last;
   logic        m_last;
   logic [31:0] sig_in;
   logic [31:0] sig_out;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic [31:0] m_axis_tdata;

   int errors = 0;
   int checks = 0;
   int n_pop  = 0;
   int max_occ = 0;
   logic [32:0] sb [$];

   always #5 aclk = ~aclk;

   sigmoid_stream_ctrl #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
`ifdef SIG_TLAST_EN
      .s_axis_tlast  (s_last),
      .m_axis_tlast  (m_last),
`endif
      .sig_in        (sig_in),
      .sig_out       (sig_out),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata)
   );

`ifndef SIG_TLAST_EN
   assign m_last = 1'b0;
`endif

   // Sigmoid stand-in: pure delay of LATENCY edges
   logic [31:0] pipe [LATENCY];
   always @(posedge aclk) begin
      pipe[0] <= sig_in;
      for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
   end
   assign sig_out = pipe[LATENCY-1];

   // Reference: handshakes due on the next edge, evaluated mid-cycle
   always @(negedge aclk) begin
      logic [32:0] exp_v;
      if (!aresetn) begin
         sb.delete();
      end else begin
         if (s_axis_tvalid && s_axis_tready) sb.push_back({s_last, s_axis_tdata});
         if (sb.size() > max_occ) max_occ = sb.size();
         if (m_axis_tvalid && m_axis_tready) begin
            n_pop++;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL order: got result %h last=%b, none outstanding", m_axis_tdata, m_last);
            end else begin
               exp_v = sb.pop_front();
               if ({m_last, m_axis_tdata} !== exp_v) begin
                  errors++;
                  $display("FAIL order: got %h last=%b, required %h last=%b",
                           m_axis_tdata, m_last, exp_v[31:0], exp_v[32]);
               end
            end
         end
      end
   end

   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   task automatic test_reset();
      aresetn = 1'b0; s_axis_tvalid = 1'b1; s_axis_tdata = 32'h1234_5678;
      s_last = 1'b0; m_axis_tready = 1'b0;
      repeat (3) cyc();
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL reset_tready: got %b, required 0", s_axis_tready); end
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b, required 0", m_axis_tvalid); end
      checks++; if (sig_in !== 32'h0) begin errors++; $display("FAIL reset_sig_in: got %h, required 0", sig_in); end
      s_axis_tvalid = 1'b0; s_axis_tdata = '0;
      aresetn = 1'b1;
      cyc();
      checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL release_tready: got %b, required 1", s_axis_tready); end
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL release_tvalid: got %b, required 0", m_axis_tvalid); end
   endtask

   task automatic test_single();
      int early = 0;
      int base  = n_pop;
      m_axis_tready = 1'b1;
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'h3F80_0000;
      #1;
      checks++; if (sig_in !== 32'h3F80_0000) begin errors++; $display("FAIL single_sig_in: got %h, required 3f800000", sig_in); end
      cyc();                                    // acceptance edge k
      s_axis_tvalid = 1'b0; s_axis_tdata = 32'hFFFF_FFFF;
      #1;
      checks++; if (sig_in !== 32'h0) begin errors++; $display("FAIL idle_sig_in: got %h, required 0", sig_in); end
      for (int i = 1; i < LATENCY; i++) begin
         cyc();
         if (m_axis_tvalid !== 1'b0) early++;
      end
      checks++; if (early != 0) begin errors++; $display("FAIL single_early: got %0d early valid cycles, required 0", early); end
      cyc();                                    // edge k+LATENCY
      checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b, required 1", m_axis_tvalid); end
      checks++; if (m_axis_tdata !== 32'h3F80_0000) begin errors++; $display("FAIL single_data: got %h, required 3f800000", m_axis_tdata); end
      cyc();
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_one_beat: got %b, required 0", m_axis_tvalid); end
      checks++; if (n_pop - base != 1) begin errors++; $display("FAIL single_count: got %0d results, required 1", n_pop - base); end
   endtask

   task automatic test_fill();
      int  idx = 0;
      int  guard = 0;
      bit  acc;
      m_axis_tready = 1'b0;
      for (int c = 0; c < 40; c++) begin
         s_axis_tvalid = (idx < 20); s_axis_tdata = 32'hA000_0000 + 32'(idx);
         acc = s_axis_tvalid && s_axis_tready;
         cyc();
         if (acc) idx++;
      end
      checks++; if (idx != DEPTH) begin errors++; $display("FAIL fill_accepted: got %0d, required %0d", idx, DEPTH); end
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL fill_tready: got %b, required 0", s_axis_tready); end
      checks++; if (m_axis_tdata !== 32'hA000_0000) begin errors++; $display("FAIL fill_head: got %h, required a0000000", m_axis_tdata); end
      m_axis_tready = 1'b1;
      while ((idx < 20 || sb.size() != 0 || m_axis_tvalid) && guard < 300) begin
         s_axis_tvalid = (idx < 20); s_axis_tdata = 32'hA000_0000 + 32'(idx);
         acc = s_axis_tvalid && s_axis_tready;
         cyc();
         if (acc) idx++;
         guard++;
      end
      s_axis_tvalid = 1'b0;
      checks++; if (guard >= 300) begin errors++; $display("FAIL fill_drain: timeout, %0d accepted %0d outstanding, required 20 and 0", idx, sb.size()); end
   endtask

   task automatic test_random();
      int  idx = 0;
      int  base = n_pop;
      int  guard = 0;
      bit  acc = 1'b1;
      max_occ = 0;
      s_axis_tvalid = 1'b0;
      for (int c = 0; c < 20000 && idx < 1000; c++) begin
         if (!s_axis_tvalid || acc) begin
            s_axis_tvalid = ($urandom_range(0, 9) < 7) && (idx < 1000);
            s_axis_tdata  = $urandom();
         end
         m_axis_tready = ($urandom_range(0, 9) < 6);
         acc = s_axis_tvalid && s_axis_tready;
         cyc();
         if (acc) idx++;
      end
      s_axis_tvalid = 1'b0; m_axis_tready = 1'b1;
      while ((sb.size() != 0 || m_axis_tvalid) && guard < 200) begin cyc(); guard++; end
      checks++; if (idx != 1000) begin errors++; $display("FAIL rand_accepted: got %0d, required 1000", idx); end
      checks++; if (n_pop - base != 1000) begin errors++; $display("FAIL rand_results: got %0d, required 1000", n_pop - base); end
      checks++; if (max_occ > DEPTH) begin errors++; $display("FAIL rand_occupancy: got %0d, required <= %0d", max_occ, DEPTH); end
      checks++; if (sb.size() != 0) begin errors++; $display("FAIL rand_leftover: got %0d, required 0", sb.size()); end
   endtask

   task automatic test_back_to_back();
      int drops = 0;
      int nvalid = 0;
      int first = -1;
      int last = -1;
      m_axis_tready = 1'b1;
      for (int c = 0; c < 130; c++) begin
         s_axis_tvalid = (c < 100); s_axis_tdata = 32'hB000_0000 + 32'(c);
         if (c < 100 && !s_axis_tready) drops++;
         cyc();
         if (m_axis_tvalid) begin
            nvalid++;
            if (first < 0) first = c;
            last = c;
         end
      end
      s_axis_tvalid = 1'b0;
      checks++; if (drops != 0) begin errors++; $display("FAIL b2b_tready: got %0d stalled cycles, required 0", drops); end
      checks++; if (nvalid != 100) begin errors++; $display("FAIL b2b_count: got %0d results, required 100", nvalid); end
      checks++; if (last - first + 1 != 100) begin errors++; $display("FAIL b2b_gapless: got span %0d, required 100", last - first + 1); end
      checks++; if (first != LATENCY) begin errors++; $display("FAIL b2b_first: got cycle %0d, required %0d", first, LATENCY); end
   endtask

   task automatic test_mid_reset();
      int leaked = 0;
      int base;
      m_axis_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         s_axis_tvalid = 1'b1; s_axis_tdata = 32'hDEAD_0000 + 32'(i); cyc();
      end
      s_axis_tvalid = 1'b0;
      repeat (LATENCY + 2) cyc();
      for (int i = 3; i < 8; i++) begin
         s_axis_tvalid = 1'b1; s_axis_tdata = 32'hDEAD_0000 + 32'(i); cyc();
      end
      checks++; if (sb.size() != 8) begin errors++; $display("FAIL mrst_setup: got %0d outstanding, required 8", sb.size()); end
      s_axis_tvalid = 1'b0; aresetn = 1'b0; m_axis_tready = 1'b1;
      cyc();
      checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL mrst_tvalid: got %b, required 0", m_axis_tvalid); end
      checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL mrst_tready: got %b, required 0", s_axis_tready); end
      aresetn = 1'b1;
      for (int c = 0; c < 3 * LATENCY; c++) begin
         cyc();
         if (m_axis_tvalid) leaked++;
      end
      checks++; if (leaked != 0) begin errors++; $display("FAIL mrst_leak: got %0d stale results, required 0", leaked); end
      base = n_pop;
      for (int i = 0; i < 3; i++) begin
         s_axis_tvalid = 1'b1; s_axis_tdata = 32'hC000_0000 + 32'(i); cyc();
      end
      s_axis_tvalid = 1'b0;
      repeat (LATENCY + 6) cyc();
      checks++; if (n_pop - base != 3) begin errors++; $display("FAIL mrst_resume: got %0d results, required 3", n_pop - base); end
   endtask

`ifdef SIG_TLAST_EN
   task automatic test_tlast();
      int idx = 0;
      int npop = 0;
      int lasts = 0;
      int bad = 0;
      bit acc;
      for (int c = 0; c < 400 && npop < 16; c++) begin
         s_axis_tvalid = (idx < 16); s_axis_tdata = 32'hE000_0000 + 32'(idx);
         s_last = (idx % 4 == 3);
         m_axis_tready = ($urandom_range(0, 1) == 1);
         acc = s_axis_tvalid && s_axis_tready;
         if (m_axis_tvalid && m_axis_tready) begin
            npop++;
            if (m_last) begin
               lasts++;
               if (npop % 4 != 0) bad++;
            end
         end
         cyc();
         if (acc) idx++;
      end
      s_axis_tvalid = 1'b0; s_last = 1'b0;
      checks++; if (lasts != 4) begin errors++; $display("FAIL tlast_count: got %0d, required 4", lasts); end
      checks++; if (bad != 0) begin errors++; $display("FAIL tlast_position: got %0d misplaced, required 0", bad); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_random();
      test_back_to_back();
      test_mid_reset();
`ifdef SIG_TLAST_EN
      test_tlast();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
